// File: rtl/rflp_pkg.sv
// Shared types and constants for the rflp register-file arbiter/sequencer.
// Widths match the 256x12 single-port macro (RA = addr[7:2], CA = addr[1:0]).
package rflp_pkg;

    localparam int AW   = 8;
    localparam int DW   = 12;
    localparam int RAW  = 6;
    localparam int CAW  = 2;
    localparam int NREQ = 2;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic [RAW-1:0] ra;
        logic [CAW-1:0] ca;
    } addr_split_t;

    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

    function automatic addr_split_t split_addr(input logic [AW-1:0] addr);
        addr_split_t s;
        s.ra = addr[AW-1:CAW];
        s.ca = addr[CAW-1:0];
        return s;
    endfunction

endpackage

// File: rtl/rflp_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie
// and flips to the other requester after every grant.
module rflp_rr_arb2
    import rflp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = '0;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/rflp_arb_ctrl.sv
// Sequencer/arbiter in front of the 256x12 register-file macro.
// Optional power-up clear of all 256 words: define RFLP_ARB_INIT_CLEAR_EN.
module rflp_arb_ctrl
    import rflp_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ_VALID,
    output logic [NREQ-1:0]    REQ_READY,
    input  logic [NREQ-1:0]    REQ_WR,
    input  logic [NREQ*AW-1:0] REQ_ADDR,
    input  logic [NREQ*DW-1:0] REQ_WDATA,
    output logic [NREQ-1:0]    RSP_VALID,
    output logic [DW-1:0]      RSP_RDATA,
    output logic               INIT_BUSY,
    output logic               MEM_NCE,
    output logic               MEM_NWRT,
    output logic [RAW-1:0]     MEM_RA,
    output logic [CAW-1:0]     MEM_CA,
    output logic [DW-1:0]      MEM_DIN,
    input  logic [DW-1:0]      MEM_DO
);

`ifdef RFLP_ARB_INIT_CLEAR_EN
    localparam state_t ST_BOOT = ST_INIT;
`else
    localparam state_t ST_BOOT = ST_RUN;
`endif

    state_t      state;
    state_t      state_nxt;
    logic        run_en;
    logic        init_wr;
    logic        init_last;
    logic [AW-1:0] init_addr;
    logic        hs;
    logic        sel;
    logic        sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    addr_split_t sel_split;
    addr_split_t init_split;
    rd_tag_t     rd_s1;
    rd_tag_t     rd_s2;

`ifdef RFLP_ARB_INIT_CLEAR_EN
    logic [AW-1:0] init_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    assign init_addr = init_cnt;
    assign init_last = (init_cnt == {AW{1'b1}});
`else
    assign init_addr = '0;
    assign init_last = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (init_last) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        run_en  = (state == ST_RUN) && !RST;
        init_wr = 1'b0;
`ifdef RFLP_ARB_INIT_CLEAR_EN
        init_wr = (state == ST_INIT) && !RST;
`endif
    end

    assign INIT_BUSY = init_wr;

    rflp_rr_arb2 u_arb (
        .clk (CLK),
        .rst (RST),
        .req (REQ_VALID),
        .en  (run_en),
        .gnt (REQ_READY)
    );

    assign hs        = |REQ_READY;
    assign sel       = REQ_READY[1];
    assign sel_wr    = sel ? REQ_WR[1] : REQ_WR[0];
    assign sel_addr  = sel ? REQ_ADDR[AW +: AW] : REQ_ADDR[0 +: AW];
    assign sel_wdata = sel ? REQ_WDATA[DW +: DW] : REQ_WDATA[0 +: DW];
    assign sel_split  = split_addr(sel_addr);
    assign init_split = split_addr(init_addr);

    // Address/data hold when idle so the macro pins only toggle on real accesses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            MEM_NCE  <= 1'b1;
            MEM_NWRT <= 1'b1;
            MEM_RA   <= '0;
            MEM_CA   <= '0;
            MEM_DIN  <= '0;
        end else if (init_wr) begin
            MEM_NCE  <= 1'b0;
            MEM_NWRT <= 1'b0;
            MEM_RA   <= init_split.ra;
            MEM_CA   <= init_split.ca;
            MEM_DIN  <= '0;
        end else if (hs) begin
            MEM_NCE  <= 1'b0;
            MEM_NWRT <= ~sel_wr;
            MEM_RA   <= sel_split.ra;
            MEM_CA   <= sel_split.ca;
            MEM_DIN  <= sel_wdata;
        end else begin
            MEM_NCE  <= 1'b1;
            MEM_NWRT <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_s1 <= '0;
            rd_s2 <= '0;
        end else begin
            rd_s1.vld <= hs && !sel_wr;
            rd_s1.id  <= sel;
            rd_s2     <= rd_s1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RSP_VALID <= '0;
            RSP_RDATA <= '0;
        end else begin
            RSP_VALID <= {rd_s2.vld && rd_s2.id, rd_s2.vld && !rd_s2.id};
            if (rd_s2.vld) begin
                RSP_RDATA <= MEM_DO;
            end
        end
    end

endmodule

// File: tb/tb_rflp_arb_ctrl.sv
// Bench for rflp_arb_ctrl: behavioural macro model plus a read scoreboard
// with exact two-edge latency and a round-robin grant model.
module tb_rflp_arb_ctrl;
    import rflp_pkg::*;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic [NREQ-1:0]    REQ_VALID = '0;
    logic [NREQ-1:0]    REQ_READY;
    logic [NREQ-1:0]    REQ_WR = '0;
    logic [NREQ*AW-1:0] REQ_ADDR = '0;
    logic [NREQ*DW-1:0] REQ_WDATA = '0;
    logic [NREQ-1:0]    RSP_VALID;
    logic [DW-1:0]      RSP_RDATA;
    logic               INIT_BUSY;
    logic               MEM_NCE;
    logic               MEM_NWRT;
    logic [RAW-1:0]     MEM_RA;
    logic [CAW-1:0]     MEM_CA;
    logic [DW-1:0]      MEM_DIN;
    logic [DW-1:0]      MEM_DO;

    rflp_arb_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WR    (REQ_WR),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .INIT_BUSY (INIT_BUSY),
        .MEM_NCE   (MEM_NCE),
        .MEM_NWRT  (MEM_NWRT),
        .MEM_RA    (MEM_RA),
        .MEM_CA    (MEM_CA),
        .MEM_DIN   (MEM_DIN),
        .MEM_DO    (MEM_DO)
    );

    always #5 CLK = ~CLK;

    // Macro model: pins sampled on the rising edge, read data valid after it.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] do_q;
    assign MEM_DO = do_q;

    always @(posedge CLK) begin
        if (!MEM_NCE) begin
            if (!MEM_NWRT) mem[{MEM_RA, MEM_CA}] <= MEM_DIN;
            else           do_q <= mem[{MEM_RA, MEM_CA}];
        end
    end

    typedef struct {
        int            due;
        logic [1:0]    vld;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] shadow [256];
    int            nvec = 0;
    int            nmis = 0;
    int            ecnt = 0;
    bit            arb_chk = 1'b0;
    logic          exp_ptr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) ecnt++;

    // Inputs change 1 ns after the rising edge, so the falling edge sees
    // exactly what the next rising edge will sample.
    always @(negedge CLK) begin
        logic [1:0]    hsv;
        logic [1:0]    exp_rdy;
        int            id;
        logic [AW-1:0] a;
        if (sbq.size() > 0 && sbq[0].due == ecnt) begin
            check("rsp_valid", 32'(RSP_VALID), 32'(sbq[0].vld));
            check("rsp_rdata", 32'(RSP_RDATA), 32'(sbq[0].data));
            void'(sbq.pop_front());
        end else begin
            check("rsp_idle", 32'(RSP_VALID), 0);
        end
        if (arb_chk && !RST) begin
            exp_rdy = (REQ_VALID == 2'b11) ? (exp_ptr ? 2'b10 : 2'b01) : REQ_VALID;
            check("req_ready", 32'(REQ_READY), 32'(exp_rdy));
        end
        if (INIT_BUSY) begin
            foreach (shadow[i]) shadow[i] = '0;
        end
        if (RST) begin
            sbq.delete();
            exp_ptr = 1'b0;
        end else begin
            hsv = REQ_VALID & REQ_READY;
            if (hsv != 2'b00) begin
                id = hsv[1] ? 1 : 0;
                exp_ptr = (id == 0);
                a = REQ_ADDR[id*AW +: AW];
                if (REQ_WR[id]) begin
                    shadow[a] = REQ_WDATA[id*DW +: DW];
                end else begin
                    sbq.push_back('{due: ecnt + 3,
                                    vld: (id == 1) ? 2'b10 : 2'b01,
                                    data: shadow[a]});
                end
            end
        end
    end

    task automatic issue(input int id, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        REQ_WR[id]             = wr;
        REQ_ADDR[id*AW +: AW]  = addr;
        REQ_WDATA[id*DW +: DW] = wd;
        REQ_VALID[id]          = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge CLK);
            if (REQ_READY[id]) break;
            if (n == 30) begin
                check("hs_timeout", 32'(REQ_READY[id]), 1);
                break;
            end
        end
        @(posedge CLK);
        #1;
        REQ_VALID[id] = 1'b0;
    endtask

    task automatic do_reset(input int n);
        arb_chk   = 1'b0;
        RST       = 1'b1;
        REQ_VALID = 2'b11;
        @(posedge CLK);
        #1;
        check("rst_nce", 32'(MEM_NCE), 1);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check("rst_ready", 32'(REQ_READY), 0);
            check("rst_rsp", 32'(RSP_VALID), 0);
            check("rst_rdata", 32'(RSP_RDATA), 0);
            check("rst_nwrt", 32'(MEM_NWRT), 1);
            check("rst_pins", 32'({MEM_RA, MEM_CA, MEM_DIN}), 0);
            check("rst_busy", 32'(INIT_BUSY), 0);
        end
        @(posedge CLK);
        #1;
        RST       = 1'b0;
        REQ_VALID = 2'b00;
`ifdef RFLP_ARB_INIT_CLEAR_EN
        REQ_WR[0]    = 1'b0;
        REQ_VALID[0] = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            check("init_busy", 32'(INIT_BUSY), 1);
            check("init_ready", 32'(REQ_READY), 0);
        end
        REQ_VALID = 2'b00;
        @(negedge CLK);
        check("init_done", 32'(INIT_BUSY), 0);
        @(posedge CLK);
        #1;
`endif
        arb_chk = 1'b1;
    endtask

    initial begin
        do_reset(3);

`ifdef RFLP_ARB_INIT_CLEAR_EN
        for (int a = 0; a < 256; a++) issue(0, 1'b1, AW'(a), 'hFFF);
        do_reset(2);
        issue(0, 1'b0, 8'hFF, '0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("init_clear", 32'(RSP_RDATA), 0);
        check("init_clear_v", 32'(RSP_VALID), 1);
`endif

        // Single write: pins driven for exactly one cycle
        issue(0, 1'b1, 8'h35, 12'hABC);
        check("wr_nce", 32'(MEM_NCE), 0);
        check("wr_nwrt", 32'(MEM_NWRT), 0);
        check("wr_ra", 32'(MEM_RA), 'h0D);
        check("wr_ca", 32'(MEM_CA), 1);
        check("wr_din", 32'(MEM_DIN), 'hABC);
        @(posedge CLK);
        #1;
        check("idle_nce", 32'(MEM_NCE), 1);
        check("idle_nwrt", 32'(MEM_NWRT), 1);
        check("idle_ra_hold", 32'(MEM_RA), 'h0D);

        // Read back with two-edge latency and one-cycle strobe
        issue(0, 1'b0, 8'h35, '0);
        @(posedge CLK);
        #1;
        check("rd_lat1", 32'(RSP_VALID), 0);
        @(posedge CLK);
        #1;
        check("rd_valid", 32'(RSP_VALID), 1);
        check("rd_data", 32'(RSP_RDATA), 'hABC);
        @(posedge CLK);
        #1;
        check("rd_pulse", 32'(RSP_VALID), 0);

        // Contended back-to-back reads alternate
        issue(0, 1'b1, 8'h00, 12'h111);
        issue(1, 1'b1, 8'hFF, 12'h222);
        REQ_WR              = 2'b00;
        REQ_ADDR[0 +: AW]   = 8'h00;
        REQ_ADDR[AW +: AW]  = 8'hFF;
        REQ_VALID           = 2'b11;
        repeat (8) @(posedge CLK);
        #1;
        REQ_VALID = 2'b00;
        repeat (4) @(posedge CLK);
        #1;

        // Write then immediate read of the same address
        issue(1, 1'b1, 8'h10, 12'h123);
        issue(1, 1'b0, 8'h10, '0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("raw_valid", 32'(RSP_VALID), 2);
        check("raw_data", 32'(RSP_RDATA), 'h123);

        // Reset right after a read handshake drops the read
        issue(0, 1'b0, 8'h35, '0);
        do_reset(3);
        REQ_WR    = 2'b00;
        REQ_VALID = 2'b11;
        @(negedge CLK);
        check("rst_ptr", 32'(REQ_READY), 1);
        @(posedge CLK);
        #1;
        REQ_VALID = 2'b00;
        issue(1, 1'b0, 8'h35, '0);
        repeat (5) @(posedge CLK);
        #1;
        check("sb_drain", 32'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nvec);
        $fatal(1);
    end

endmodule
